// File: rtl/draw_pkg.sv
// Shared constants, widths and state encoding for the sprite draw sequencer.
package draw_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int BOX_W    = 40;
  localparam int BOX_H    = 40;

  localparam int X_W    = 8;
  localparam int Y_W    = 7;
  localparam int MSEL_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } draw_state_e;

endpackage

// File: rtl/scan_counter_2d.sv
// Column/row scan counter with a row-major linear address kept as its own
// incrementing counter, so no multiplier is needed. Holds on the last pixel.
module scan_counter_2d
  import draw_pkg::*;
#(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [X_W-1:0]    i_width,
  input  logic [Y_W-1:0]    i_height,
  output logic [X_W-1:0]    o_col,
  output logic [Y_W-1:0]    o_row,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  logic [X_W-1:0]    r_col;
  logic [Y_W-1:0]    r_row;
  logic [ADDR_W-1:0] r_addr;
  logic              w_col_last;
  logic              w_row_last;

  assign w_col_last = (r_col == i_width - 1'b1);
  assign w_row_last = (r_row == i_height - 1'b1);
  assign o_last     = w_col_last && w_row_last;
  assign o_col      = r_col;
  assign o_row      = r_row;
  assign o_addr     = r_addr;

  // Advance one pixel per enabled cycle; clear on a new draw; freeze on the last pixel.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_col  <= '0;
      r_row  <= '0;
      r_addr <= '0;
    end else if (i_clr) begin
      r_col  <= '0;
      r_row  <= '0;
      r_addr <= '0;
    end else if (i_en && !o_last) begin
      r_addr <= r_addr + 1'b1;
      if (w_col_last) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_draw_seq.sv
// Sprite/screen draw sequencer: scans a box or the full screen one pixel per
// clock, issuing the ROM address and presenting x/y/plot one cycle later.
// Optional abort input enabled by defining DRAW_ABORT_EN.
module sprite_draw_seq
  import draw_pkg::*;
#(
  parameter int BOX_W    = draw_pkg::BOX_W,
  parameter int BOX_H    = draw_pkg::BOX_H,
  parameter int SCREEN_W = draw_pkg::SCREEN_W,
  parameter int SCREEN_H = draw_pkg::SCREEN_H,
  parameter int ADDR_W   = 15
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              fullScreen,
  input  logic              blackIn,
  input  logic [4:0]        memorySelIn,
  input  logic [7:0]        xInit,
  input  logic [6:0]        yInit,
  output logic [ADDR_W-1:0] romAddr,
  output logic [4:0]        memorySel,
  output logic              black,
  output logic [7:0]        x,
  output logic [6:0]        y,
  output logic              plot,
  output logic              busy,
  output logic              done
`ifdef DRAW_ABORT_EN
  ,
  input  logic              abort
`endif
);

  draw_state_e r_state;
  draw_state_e w_state_nxt;

  logic [X_W-1:0]    r_orig_x;
  logic [Y_W-1:0]    r_orig_y;
  logic [X_W-1:0]    r_width;
  logic [Y_W-1:0]    r_height;
  logic [MSEL_W-1:0] r_msel;
  logic              r_black;
  logic [X_W-1:0]    r_x;
  logic [Y_W-1:0]    r_y;
  logic              r_plot;
  logic              r_busy;
  logic              r_done;

  logic [X_W-1:0]    w_col;
  logic [Y_W-1:0]    w_row;
  logic [ADDR_W-1:0] w_addr;
  logic              w_last;
  logic [X_W:0]      w_sum_x;
  logic [Y_W:0]      w_sum_y;
  logic              w_clip;
  logic              w_abort;

  logic              w_latch;
  logic              w_cnt_en;
  logic              w_xy_load;
  logic              w_plot_d;
  logic              w_busy_d;
  logic              w_done_d;

`ifdef DRAW_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  scan_counter_2d #(
    .ADDR_W(ADDR_W)
  ) u_scan (
    .clk     (clk),
    .resetn  (resetn),
    .i_clr   (w_latch),
    .i_en    (w_cnt_en),
    .i_width (r_width),
    .i_height(r_height),
    .o_col   (w_col),
    .o_row   (w_row),
    .o_addr  (w_addr),
    .o_last  (w_last)
  );

  // Screen coordinates one bit wider so off-screen pixels clip instead of wrapping.
  assign w_sum_x = {1'b0, r_orig_x} + {1'b0, w_col};
  assign w_sum_y = {1'b0, r_orig_y} + {1'b0, w_row};
  assign w_clip  = (w_sum_x >= (X_W+1)'(SCREEN_W)) || (w_sum_y >= (Y_W+1)'(SCREEN_H));

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = SCAN;
      SCAN:    if (w_abort) w_state_nxt = IDLE;
               else if (w_last) w_state_nxt = FLUSH;
      FLUSH:   w_state_nxt = w_abort ? IDLE : DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output/control decode: next values for the registered outputs.
  always_comb begin
    w_latch   = 1'b0;
    w_cnt_en  = 1'b0;
    w_xy_load = 1'b0;
    w_plot_d  = 1'b0;
    w_busy_d  = 1'b0;
    w_done_d  = 1'b0;
    case (r_state)
      IDLE: begin
        w_latch  = start;
        w_busy_d = start;
      end
      SCAN: begin
        w_cnt_en  = !w_abort;
        w_xy_load = !w_abort;
        w_plot_d  = !w_abort && !w_clip;
        w_busy_d  = !w_abort;
      end
      FLUSH: begin
        // busy drops on the same edge that raises done
        w_done_d = !w_abort;
      end
      default: ;
    endcase
  end

  // Latched draw context and the one-stage output pipeline.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_orig_x <= '0;
      r_orig_y <= '0;
      r_width  <= '0;
      r_height <= '0;
      r_msel   <= '0;
      r_black  <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_plot   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      if (w_latch) begin
        r_msel   <= memorySelIn;
        r_black  <= blackIn;
        r_orig_x <= fullScreen ? '0 : xInit;
        r_orig_y <= fullScreen ? '0 : yInit;
        r_width  <= fullScreen ? X_W'(SCREEN_W) : X_W'(BOX_W);
        r_height <= fullScreen ? Y_W'(SCREEN_H) : Y_W'(BOX_H);
      end
      if (w_xy_load) begin
        r_x <= w_sum_x[X_W-1:0];
        r_y <= w_sum_y[Y_W-1:0];
      end
      r_plot <= w_plot_d;
      r_busy <= w_busy_d;
      r_done <= w_done_d;
    end
  end

  assign romAddr   = w_addr;
  assign memorySel = r_msel;
  assign black     = r_black;
  assign x         = r_x;
  assign y         = r_y;
  assign plot      = r_plot;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: doc/sprite_draw_seq.md
Name: sprite_draw_seq

Overview:
- Draw sequencer that feeds the VGA adapter from the position registers and the colour mux.
- On a start pulse it latches the initial X/Y, the sprite memory select and the black/full-screen flags, then scans every pixel of the region, one per clock.
- For each pixel it issues the sprite ROM read address, then presents x, y and plot aligned with the ROM's 1-cycle read data. It pulses done when the region is finished.

Parameters:
- BOX_W, 40, sprite width in pixels (battle sprites).
- BOX_H, 40, sprite height in pixels.
- SCREEN_W, 160, screen width; also the full-screen scan width.
- SCREEN_H, 120, screen height; also the full-screen scan height.
- ADDR_W, 15, ROM address width; must satisfy 2^ADDR_W >= SCREEN_W*SCREEN_H.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to begin a draw; ignored while busy
- fullScreen  in  1  1 = scan SCREEN_W x SCREEN_H from (0,0); 0 = scan BOX_W x BOX_H from (xInit,yInit)
- blackIn  in  1  1 = draw black (clear) instead of ROM colour
- memorySelIn  in  5  sprite/screen memory select
- xInit  in  8  box origin X (from the xInit register)
- yInit  in  7  box origin Y (from the yInit register)
- romAddr  out  ADDR_W  ROM read address, row-major offset within the region
- memorySel  out  5  latched memory select, to the colour mux
- black  out  1  latched black flag, to the colour mux
- x  out  8  pixel X, aligned with the ROM data
- y  out  7  pixel Y, aligned with the ROM data
- plot  out  1  VGA write enable for (x, y)
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle pulse when the draw completes

Behaviour:
- Reset values: all outputs 0 (romAddr, memorySel, black, x, y, plot, busy, done); state IDLE; counters 0.
- States: IDLE, SCAN, FLUSH, DONE.
- IDLE: on start=1, latch fullScreen, blackIn, memorySelIn, xInit and yInit. Then:
  - origin = (0,0) if fullScreen, else (xInit, yInit);
  - width/height = SCREEN_W/SCREEN_H if fullScreen, else BOX_W/BOX_H;
  - col = row = romAddr = 0; busy = 1; go to SCAN.
- SCAN (one pixel per cycle):
  - romAddr = row*width + col, kept as an incrementing counter with no multiplier.
  - col increments; when col == width-1, col wraps to 0 and row increments.
  - At col == width-1 and row == height-1, go to FLUSH after this cycle.
- Output pipeline (stage 1): x = origin.x+col, y = origin.y+row and plot are registered from the SCAN-cycle values. Total latency from address to plot is 1 cycle, matching the ROM.
- Clipping: when origin.x+col >= SCREEN_W or origin.y+row >= SCREEN_H, plot = 0 for that pixel, but romAddr still advances. Sums are computed 1 bit wider before comparison; the x/y outputs are truncated to 8/7 bits.
- FLUSH: one cycle so the last pixel's plot is presented; romAddr holds. Then go to DONE.
- DONE: done = 1 for exactly one cycle, busy = 0 at the same edge; return to IDLE.
- start asserted during SCAN, FLUSH or DONE is ignored, not queued. start on the cycle after DONE is accepted.
- Pixel counts:
  - box draw: exactly BOX_W*BOX_H = 1600 plot pulses (fewer if clipped); start to done = 1600+2 cycles;
  - full-screen draw: 19200 plot pulses.
- memorySel and black hold their latched values until the next accepted start. They are stable for every plot of a draw.
- resetn low mid-draw: immediate asynchronous return to IDLE with all outputs 0. No done pulse.

Optional Feature:
- Macro DRAW_ABORT_EN.
- Defined: adds input port abort (1 bit). abort=1 in SCAN or FLUSH → next state IDLE, plot=0 from the next cycle, busy=0, no done pulse, latched memorySel/black retained. abort=1 in IDLE has no effect.
- Undefined: no abort port; every accepted draw runs to completion.

Decomposition:
- Shared package draw_pkg holds:
  - constants SCREEN_W=160, SCREEN_H=120, BOX_W=40, BOX_H=40;
  - the state encoding typedef (IDLE, SCAN, FLUSH, DONE);
  - widths X_W=8, Y_W=7, MSEL_W=5.
- One sub-module, scan_counter_2d: col/row/linear-address counter with width/height inputs and a last-pixel flag. The FSM and output pipeline stay in sprite_draw_seq.

Test Plan:
- Reset, then start with fullScreen=0, xInit=36, yInit=30, memorySelIn=10 → first plot at x=36, y=30, romAddr 0 issued one cycle earlier. Last plot at x=75, y=69 with romAddr 1599. 1600 plots; done 1602 cycles after start; memorySel=10 throughout.
- fullScreen=1, blackIn=1 → 19200 plots covering x 0..159, y 0..119, black=1 on every plot, done single pulse.
- Box at xInit=140, yInit=100 → plots only for x 140..159 and y 100..119 (400 plots). romAddr still reaches 1599; done timing unchanged.
- start pulsed again mid-SCAN with different memorySelIn → ignored; memorySel unchanged; exactly one done. start one cycle after done → accepted.
- resetn dropped at pixel 500 → all outputs 0 immediately, no done. Next start begins at romAddr 0.
- With DRAW_ABORT_EN: abort at pixel 200 → plot low from the next cycle, busy=0, no done. A new start is accepted the following cycle.
